// File: rtl/rom_burst_sequencer.sv
// rtl/rom_burst_sequencer.sv - walks a small combinational ROM in bursts and presents words over valid/ready
module rom_burst_sequencer #(
   parameter int AW = 3,
   parameter int DW = 9
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [AW-1:0] start_addr,
   input  logic [AW:0]   count,
   output logic [AW-1:0] rom_addr,
   input  logic [DW-1:0] rom_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic          out_last,
   output logic          busy,
   output logic          done
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FETCH   = 2'd1,
      PRESENT = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t        state;
   state_t        state_next;
   logic [AW-1:0] ptr;
   logic [AW:0]   remaining;
   logic          handshake;
   logic          final_word;

   // The pointer register is the only source of the ROM address.
   assign rom_addr   = ptr;
   assign handshake  = out_valid && out_ready;
   assign final_word = (remaining == (AW+1)'(1));
   assign busy       = (state != IDLE);
   assign done       = (state == DONE);

   // State register; reset returns to IDLE from anywhere, overriding start.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode; start is only looked at in IDLE so commands during a burst are dropped.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = (count != '0) ? FETCH : DONE;
            end
         end
         FETCH: begin
            state_next = PRESENT;
         end
         PRESENT: begin
            if (handshake) begin
               state_next = final_word ? DONE : FETCH;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Burst bookkeeping and the output word register; the word is held until it is accepted.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr       <= '0;
         remaining <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_data  <= '0;
      end else begin
         case (state)
            IDLE: begin
               // Burst parameters are latched only here, at the accepting edge.
               if (start && (count != '0)) begin
                  ptr       <= start_addr;
                  remaining <= count;
               end
            end
            FETCH: begin
               out_data  <= rom_data;
               out_valid <= 1'b1;
               out_last  <= final_word;
            end
            PRESENT: begin
               if (handshake) begin
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
                  if (!final_word) begin
                     remaining <= remaining - (AW+1)'(1);
                     // Natural AW-bit overflow gives the 7 -> 0 wrap.
                     ptr       <= ptr + AW'(1);
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rom_burst_sequencer.sv
// tb/tb_rom_burst_sequencer.sv - scoreboard bench for rom_burst_sequencer
module tb_rom_burst_sequencer;

   logic       clk;
   logic       rst;
   logic       start;
   logic [2:0] start_addr;
   logic [3:0] count;
   logic [2:0] rom_addr;
   logic [8:0] rom_data;
   logic       out_valid;
   logic       out_ready;
   logic [8:0] out_data;
   logic       out_last;
   logic       busy;
   logic       done;

   logic [8:0] rom [8] = '{9'h04C, 9'h096, 9'h1D5, 9'h1AC, 9'h080, 9'h195, 9'h1EC, 9'h11D};

   logic [9:0] exp_q [$];
   int checks   = 0;
   int failures = 0;
   int hs_cnt   = 0;
   int done_cnt = 0;

   assign rom_data = rom[rom_addr];

   rom_burst_sequencer #(.AW(3), .DW(9)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .start_addr (start_addr),
      .count      (count),
      .rom_addr   (rom_addr),
      .rom_data   (rom_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_last   (out_last),
      .busy       (busy),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push_burst(input int sa, input int cnt);
      for (int i = 0; i < cnt; i++) begin
         exp_q.push_back({(i == cnt - 1) ? 1'b1 : 1'b0, rom[(sa + i) % 8]});
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Counts edges until done is seen; expired bound reports as a failed check.
   task automatic wait_done(input string tag, input int exp_edges);
      int n;
      bit found;
      found = 1'b0;
      n = 0;
      while (!found && n < 200) begin
         tick();
         n++;
         if (done) found = 1'b1;
      end
      chk({tag, "_done_seen"}, found, 1);
      chk({tag, "_done_latency"}, n, exp_edges);
   endtask

   task automatic wait_hs(input int target);
      int n;
      n = 0;
      while (hs_cnt < target && n < 200) begin
         tick();
         n++;
      end
      chk("wait_handshakes", (hs_cnt >= target), 1);
   endtask

   // Monitor: compares each accepted word against the scoreboard and counts done pulses.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         hs_cnt++;
         if (exp_q.size() == 0) begin
            chk("unexpected_word", {out_last, out_data}, 10'h3FF);
         end else begin
            chk("word", {out_last, out_data}, exp_q.pop_front());
         end
      end
      if (done) begin
         done_cnt++;
         chk("done_implies_busy", busy, 1);
      end
   end

   initial begin
      int hs0;
      int dn0;

      rst        = 1'b1;
      start      = 1'b0;
      start_addr = '0;
      count      = '0;
      out_ready  = 1'b0;

      // Reset then idle
      tick();
      tick();
      chk("rst_rom_addr", rom_addr, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_out_data", out_data, 0);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("idle_hold", {rom_addr, out_valid, busy, done}, 0);
      end

      // Simple burst: 1, count 3
      push_burst(1, 3);
      hs0 = hs_cnt;
      dn0 = done_cnt;
      out_ready  = 1'b1;
      start_addr = 3'd1;
      count      = 4'd3;
      start      = 1'b1;
      tick();
      start = 1'b0;
      chk("simple_fetch_valid", out_valid, 0);
      chk("simple_fetch_busy", busy, 1);
      chk("simple_fetch_addr", rom_addr, 1);
      tick();
      chk("simple_first_valid", out_valid, 1);
      chk("simple_first_data", out_data, 9'h096);
      wait_done("simple", 5);
      tick();
      chk("simple_busy_low", busy, 0);
      chk("simple_hs", hs_cnt - hs0, 3);
      chk("simple_done_cnt", done_cnt - dn0, 1);

      // Wrap and full depth: 6, count 8
      push_burst(6, 8);
      hs0 = hs_cnt;
      dn0 = done_cnt;
      start_addr = 3'd6;
      count      = 4'd8;
      start      = 1'b1;
      tick();
      start = 1'b0;
      wait_done("full", 16);
      tick();
      chk("full_hs", hs_cnt - hs0, 8);
      chk("full_done_cnt", done_cnt - dn0, 1);
      chk("full_q_empty", exp_q.size(), 0);

      // Backpressure with ignored start pulses: 3, count 2
      push_burst(3, 2);
      hs0 = hs_cnt;
      dn0 = done_cnt;
      out_ready  = 1'b0;
      start_addr = 3'd3;
      count      = 4'd2;
      start      = 1'b1;
      tick();
      start_addr = 3'd0;
      count      = 4'd5;
      tick();
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("stall_valid_data", {out_valid, out_last, out_data}, {2'b10, 9'h1AC});
         if (i == 2) start = 1'b1;
         if (i == 3) start = 1'b0;
         tick();
      end
      out_ready = 1'b1;
      wait_done("stall", 3);
      tick();
      chk("stall_busy_low", busy, 0);
      for (int i = 0; i < 4; i++) tick();
      chk("stall_hs", hs_cnt - hs0, 2);
      chk("stall_done_cnt", done_cnt - dn0, 1);
      chk("stall_q_empty", exp_q.size(), 0);

      // Zero count
      hs0 = hs_cnt;
      count = 4'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("zero_done", {done, busy, out_valid}, 3'b110);
      tick();
      chk("zero_after", {done, busy, out_valid}, 3'b000);
      chk("zero_hs", hs_cnt - hs0, 0);

      // Reset mid-burst: 0, count 5, reset after second handshake
      push_burst(0, 5);
      hs0 = hs_cnt;
      start_addr = 3'd0;
      count      = 4'd5;
      start      = 1'b1;
      tick();
      start = 1'b0;
      wait_hs(hs0 + 2);
      dn0 = done_cnt;
      rst   = 1'b1;
      start = 1'b1;
      exp_q.delete();
      tick();
      chk("midrst_state", {rom_addr, out_valid, out_last, out_data, busy, done}, 0);
      rst   = 1'b0;
      start = 1'b0;
      tick();
      tick();
      chk("midrst_no_done", done_cnt - dn0, 0);
      chk("midrst_idle", busy, 0);

      // New burst after reset: 4, count 1
      push_burst(4, 1);
      hs0 = hs_cnt;
      start_addr = 3'd4;
      count      = 4'd1;
      start      = 1'b1;
      tick();
      start = 1'b0;
      tick();
      chk("post_rst_word", {out_valid, out_last, out_data}, {2'b11, 9'h080});
      wait_done("post_rst", 1);
      chk("post_rst_hs", hs_cnt - hs0, 1);
      chk("final_q_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
